cursor_repeat_ctrl: RTL

- Sequences the debounced button levels into cursor moves and select events for the 9x9 sudoku grid.
- Arbitrates the four direction buttons so only one owns the cursor at a time.
- Generates keyboard-style auto-repeat: an initial delay, then a fixed repeat rate.
- Sits between the button debounce stage and the game/board logic, which consumes row/col, move_pulse and sel_pulse.

---
 rtl/cursor_repeat_if.sv | 14 +
 rtl/cursor_repeat_ctrl.sv | 86 ++++++++
 2 files changed

// File: rtl/cursor_repeat_if.sv
// cursor_repeat_if: button levels in, cursor position and event strobes out
interface cursor_repeat_if;
  logic [4:0] btn_level;
  logic [3:0] row;
  logic [3:0] col;
  logic       move_pulse;
  logic       sel_pulse;
  logic [3:0] sel_row;
  logic [3:0] sel_col;
  logic [1:0] owner;
  logic       busy;
  modport master(output btn_level, input row, col, move_pulse, sel_pulse, sel_row, sel_col, owner, busy);
  modport slave(input btn_level, output row, col, move_pulse, sel_pulse, sel_row, sel_col, owner, busy);
endinterface

// File: rtl/cursor_repeat_ctrl.sv
// cursor_repeat_ctrl: arbitrated cursor auto-repeat and select edge for a GRIDxGRID board; CURSOR_WRAP_EN selects toroidal wrap instead of edge saturation
module cursor_repeat_ctrl #(
  parameter int DELAY_CYC  = 3000000,
  parameter int REPEAT_CYC = 900000,
  parameter int CNT_W      = 22,
  parameter int GRID       = 9
) (
  input logic clk,
  input logic rst,
  cursor_repeat_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  localparam logic [CNT_W-1:0] D_END = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] R_END = CNT_W'(REPEAT_CYC - 1);
  localparam logic [3:0] LAST = 4'(GRID - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0] pick, own;
  logic mv, ok, edge_hit, sel_q, sel_rise;
  logic [3:0] row_n, col_n;
  assign pick = bus.btn_level[0] ? 2'd0 : bus.btn_level[1] ? 2'd1 : bus.btn_level[2] ? 2'd2 : 2'd3;
  assign own = (state == IDLE) ? pick : bus.owner;
  assign edge_hit = own == 2'd0 ? bus.row == 4'd0 : own == 2'd1 ? bus.row == LAST : own == 2'd2 ? bus.col == 4'd0 : bus.col == LAST;
  assign row_n = own == 2'd0 ? (edge_hit ? LAST : bus.row - 4'd1) : own == 2'd1 ? (edge_hit ? 4'd0 : bus.row + 4'd1) : bus.row;
  assign col_n = own == 2'd2 ? (edge_hit ? LAST : bus.col - 4'd1) : own == 2'd3 ? (edge_hit ? 4'd0 : bus.col + 4'd1) : bus.col;
`ifdef CURSOR_WRAP_EN
  assign ok = 1'b1;
`else
  assign ok = !edge_hit;
`endif
  assign sel_rise = bus.btn_level[4] & ~sel_q;
  // direction FSM: release beats the counter terminal; both terminals share one counter
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mv = 1'b0;
    if (state == IDLE) begin
      if (|bus.btn_level[3:0]) begin
        state_n = HOLD;
        cnt_n = '0;
        mv = 1'b1;
      end
    end else if (!bus.btn_level[bus.owner]) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (cnt == ((state == HOLD) ? D_END : R_END)) begin
      state_n = REPEAT;
      cnt_n = '0;
      mv = 1'b1;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end
  // state, cursor and strobe registers; select captures the pre-move position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sel_q <= 1'b0;
      bus.row <= '0;
      bus.col <= '0;
      bus.move_pulse <= 1'b0;
      bus.sel_pulse <= 1'b0;
      bus.sel_row <= '0;
      bus.sel_col <= '0;
      bus.owner <= '0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus.busy <= state_n != IDLE;
      bus.move_pulse <= mv & ok;
      if (mv) bus.owner <= own;
      if (mv & ok) begin
        bus.row <= row_n;
        bus.col <= col_n;
      end
      sel_q <= bus.btn_level[4];
      bus.sel_pulse <= sel_rise;
      if (sel_rise) begin
        bus.sel_row <= bus.row;
        bus.sel_col <= bus.col;
      end
    end
  end
endmodule
